// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional encoder and Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K_DEFAULT       = 3;
  localparam logic [2:0]  G0_DEFAULT      = 3'b111;  // octal 7
  localparam logic [2:0]  G1_DEFAULT      = 3'b101;  // octal 5
  localparam int unsigned MAX_LEN_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  // Rate-2/3 puncturing: even data symbols send both bits, odd ones drop d_out[0].
  localparam logic [1:0] PUNCT_EVEN = 2'b11;
  localparam logic [1:0] PUNCT_ODD  = 2'b10;
  localparam logic [1:0] MASK_ALL   = 2'b11;

endpackage

// File: rtl/conv_parity.sv
// One generator tap of the convolutional encoder: parity of the register masked by g_i.
module conv_parity #(
  parameter int unsigned K = 3
) (
  input  logic [K-1:0] r_i,
  input  logic [K-1:0] g_i,
  output logic         p_o
);

  assign p_o = ^(r_i & g_i);

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed K-constraint, rate-1/2 convolutional encoder with zero-tail termination.
// One registered code symbol per accepted bit; K-1 tail symbols end each frame in state 0.
// Optional macro CONV_PUNCT_EN adds a rate-2/3 puncturing mask on data symbols.
module conv_encoder_framed
  import viterbi_pkg::*;
#(
  parameter int unsigned  K       = K_DEFAULT,
  parameter logic [K-1:0] G0      = G0_DEFAULT,
  parameter logic [K-1:0] G1      = G1_DEFAULT,
  parameter int unsigned  MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  input  logic       sof_i,
  input  logic       eof_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic [1:0] mask_o,
  output logic       eof_o,
  output logic       err_o
);

  localparam int unsigned LenW  = $clog2(MAX_LEN + 1);
  localparam int unsigned TailW = (K > 2) ? $clog2(K - 1) : 1;
  // A one-bit frame already hits the length limit when MAX_LEN is 1.
  localparam bit          FirstIsMax = (MAX_LEN <= 1);

  enc_state_e        state_q, state_d;
  logic [K-2:0]      sr_q, sr_d, sr_base;
  logic [LenW-1:0]   len_q, len_d, len_inc;
  logic [TailW-1:0]  tail_q, tail_d;
  logic              enc, d_bit, err_d, eof_d;
  logic [K-1:0]      r;
  logic              p_g0, p_g1;
  logic [1:0]        mask_d;

  logic              valid_q, eof_q, err_q;
  logic [1:0]        d_out_q, mask_q;

  // Register {newest bit, shift register}; shift register is cleared at frame start.
  assign r = {d_bit, sr_base};

  conv_parity #(.K(K)) u_parity_g0 (
    .r_i (r),
    .g_i (G0),
    .p_o (p_g0)
  );

  conv_parity #(.K(K)) u_parity_g1 (
    .r_i (r),
    .g_i (G1),
    .p_o (p_g1)
  );

  // Saturating frame length increment.
  assign len_inc = (len_q == LenW'(MAX_LEN)) ? len_q : len_q + LenW'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and encode control.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tail_d  = tail_q;
    enc     = 1'b0;
    d_bit   = 1'b0;
    sr_base = sr_q;
    err_d   = 1'b0;
    eof_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        len_d  = '0;
        tail_d = '0;
        if (enable_i) begin
          if (sof_i) begin
            enc     = 1'b1;
            d_bit   = d_in;
            sr_base = '0;
            len_d   = LenW'(1);
            if (eof_i || FirstIsMax) begin
              state_d = TAIL;
              err_d   = !eof_i;
            end else begin
              state_d = DATA;
            end
          end else begin
            // Data outside a frame is discarded.
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (enable_i) begin
          enc   = 1'b1;
          d_bit = d_in;
          err_d = sof_i;
          len_d = len_inc;
          if (eof_i || (len_inc == LenW'(MAX_LEN))) begin
            state_d = TAIL;
            tail_d  = '0;
            if (!eof_i) err_d = 1'b1;
          end
        end
      end
      TAIL: begin
        enc   = 1'b1;
        err_d = enable_i;
        if (tail_q == TailW'(K - 2)) begin
          eof_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tail_d = tail_q + TailW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-register update: the newest K-1 bits of r, zeroed after the last tail symbol.
  always_comb begin
    sr_d = sr_q;
    if (enc) sr_d = r[K-1:1];
    if (eof_d) sr_d = '0;
  end

`ifdef CONV_PUNCT_EN
  logic phase_q, phase_d, phase_cur;

  // Puncture phase: even/odd data symbol index within the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase restarts at frame start; tail symbols are never punctured.
  always_comb begin
    phase_cur = (state_q == IDLE) ? 1'b0 : phase_q;
    phase_d   = phase_q;
    mask_d    = PUNCT_EVEN;
    if (enc && (state_q != TAIL)) begin
      phase_d = ~phase_cur;
      mask_d  = phase_cur ? PUNCT_ODD : PUNCT_EVEN;
    end
  end
`else
  assign mask_d = MASK_ALL;
`endif

  // Datapath state: shift register, frame length and tail counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      len_q  <= '0;
      tail_q <= '0;
    end else begin
      sr_q   <= sr_d;
      len_q  <= len_d;
      tail_q <= tail_d;
    end
  end

  // Registered symbol outputs, one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      d_out_q <= '0;
      mask_q  <= '0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= enc;
      d_out_q <= enc ? {p_g0, p_g1} : 2'b00;
      mask_q  <= mask_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  // Outputs: ready is a pure function of state, the rest come from the output registers.
  always_comb begin
    ready_o = (state_q != TAIL);
    valid_o = valid_q;
    d_out   = d_out_q;
    mask_o  = mask_q;
    eof_o   = eof_q;
    err_o   = err_q;
  end

endmodule
